// File: rtl/engine_job_ctrl_if.sv
// Control/status channel between the job controller, the engine wrapper and its stream movers.
// master = job controller side, slave = engine/streamer side.
interface engine_job_ctrl_if #(
  parameter int N_IN  = 1,
  parameter int N_OUT = 1,
  parameter int LEN_W = 16
);
  logic [N_IN-1:0]        src_start_o;
  logic [N_IN-1:0]        src_done_i;
  logic [N_OUT-1:0]       sink_start_o;
  logic [N_OUT-1:0]       sink_done_i;
  logic                   eng_start_o;
  logic [N_IN*LEN_W-1:0]  eng_max_in_o;
  logic [N_OUT*LEN_W-1:0] eng_max_out_o;
  logic                   eng_clear_o;
  logic                   eng_done_i;
  logic                   eng_ready_i;
  logic                   eng_idle_i;

  modport master (
    output src_start_o, sink_start_o, eng_start_o, eng_max_in_o, eng_max_out_o, eng_clear_o,
    input  src_done_i, sink_done_i, eng_done_i, eng_ready_i, eng_idle_i
  );

  modport slave (
    input  src_start_o, sink_start_o, eng_start_o, eng_max_in_o, eng_max_out_o, eng_clear_o,
    output src_done_i, sink_done_i, eng_done_i, eng_ready_i, eng_idle_i
  );
endinterface

// File: rtl/engine_job_ctrl.sv
// Job sequencer: starts engine + streamers, gathers their completions, reports one end-of-job event.
// Trigger->eng_start 1 cycle, last done->evt_o 2 cycles; no backpressure, triggers outside IDLE are dropped.
module engine_job_ctrl #(
  parameter int N_IN  = 1,
  parameter int N_OUT = 1,
  parameter int LEN_W = 16,
  parameter int TO_W  = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  input  logic                   trigger_i,
  input  logic [N_IN*LEN_W-1:0]  len_in_i,
  input  logic [N_OUT*LEN_W-1:0] len_out_i,
  input  logic [TO_W-1:0]        timeout_i,
  engine_job_ctrl_if.master      ctl,
  output logic                   busy_o,
  output logic                   evt_o,
  output logic                   err_len_o,
  output logic                   err_timeout_o,
  output logic [31:0]            cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [N_IN*LEN_W-1:0]  r_max_in;
  logic [N_OUT*LEN_W-1:0] r_max_out;
  logic [N_IN-1:0]        r_src_seen;
  logic [N_OUT-1:0]       r_sink_seen;
  logic                   r_eng_seen;
  logic [31:0]            r_cycles;
  logic [TO_W-1:0]        r_wdog;
  logic [TO_W-1:0]        w_wdog_nxt;
  logic                   r_err_len;
  logic                   r_err_to;
  logic                   r_len_evt;
  logic                   r_clr_dly;
  logic                   w_len_zero;
  logic                   w_all_done;
  logic                   w_timeout;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_eng_start;
  logic                   w_eng_clear;
  logic                   w_busy;
  logic                   w_evt;
  logic                   w_unused;

  // Status-only engine flags and test mode carry no function here.
  assign w_unused = ^{test_mode_i, ctl.eng_ready_i, ctl.eng_idle_i};

  always_comb begin
    w_len_zero = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (len_in_i[k*LEN_W +: LEN_W] == '0) w_len_zero = 1'b1;
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (len_out_i[k*LEN_W +: LEN_W] == '0) w_len_zero = 1'b1;
    end
  end

  // Done inputs arriving this cycle count toward completion alongside the sticky bits.
  assign w_all_done = (&(r_src_seen | ctl.src_done_i)) &
                      (&(r_sink_seen | ctl.sink_done_i)) &
                      (r_eng_seen | ctl.eng_done_i);
  assign w_wdog_nxt = r_wdog + TO_W'(1);
  assign w_timeout  = (timeout_i != '0) && (w_wdog_nxt == timeout_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_eng_start = 1'b0;
    w_eng_clear = r_clr_dly;
    w_evt       = r_len_evt;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (trigger_i) begin
          if (w_len_zero) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_START;
          end
        end
      end
      S_START: begin
        w_eng_start = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_all_done || w_timeout) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_eng_clear = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_evt       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear_i) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_max_in    <= '0;
      r_max_out   <= '0;
      r_src_seen  <= '0;
      r_sink_seen <= '0;
      r_eng_seen  <= 1'b0;
      r_cycles    <= '0;
      r_wdog      <= '0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
      r_len_evt   <= 1'b0;
      r_clr_dly   <= 1'b0;
    end else begin
      r_len_evt <= 1'b0;
      r_clr_dly <= clear_i;
      if (clear_i) begin
        r_src_seen  <= '0;
        r_sink_seen <= '0;
        r_eng_seen  <= 1'b0;
        r_cycles    <= '0;
        r_wdog      <= '0;
        r_err_len   <= 1'b0;
        r_err_to    <= 1'b0;
      end else begin
        if (w_reject) begin
          r_err_len <= 1'b1;
          r_len_evt <= 1'b1;
        end
        if (w_accept) begin
          r_max_in    <= len_in_i;
          r_max_out   <= len_out_i;
          r_src_seen  <= '0;
          r_sink_seen <= '0;
          r_eng_seen  <= 1'b0;
          r_cycles    <= '0;
          r_wdog      <= '0;
        end
        if (r_state == S_RUN) begin
          r_src_seen  <= r_src_seen | ctl.src_done_i;
          r_sink_seen <= r_sink_seen | ctl.sink_done_i;
          r_eng_seen  <= r_eng_seen | ctl.eng_done_i;
          r_wdog      <= w_wdog_nxt;
          if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
          // Completion wins a same-cycle tie with the watchdog.
          if (!w_all_done && w_timeout) r_err_to <= 1'b1;
        end
      end
    end
  end

  assign ctl.eng_start_o   = w_eng_start;
  assign ctl.src_start_o   = {N_IN{w_eng_start}};
  assign ctl.sink_start_o  = {N_OUT{w_eng_start}};
  assign ctl.eng_clear_o   = w_eng_clear;
  assign ctl.eng_max_in_o  = r_max_in;
  assign ctl.eng_max_out_o = r_max_out;
  assign busy_o            = w_busy;
  assign evt_o             = w_evt;
  assign err_len_o         = r_err_len;
  assign err_timeout_o     = r_err_to;
  assign cycles_o          = r_cycles;

endmodule
